// File: rtl/spi_sram_responder.sv
// spi_sram_responder: SPI mode-0 serial SRAM target (READ 0x03 / WRITE 0x02).
// Optional fast read (0x0B + 8 dummy clocks) under SPI_RESPONDER_FAST_READ_EN.
module spi_sram_responder #(
   parameter int ADDR_BITS = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk,
   input  logic spi_select,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic spi_miso_oe
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int SW = ((ADDR_BITS > 8) ? ADDR_BITS : 8) - 1;
   localparam logic [ADDR_BITS-1:0] A_ONE = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_READ,
      ST_WRITE,
      ST_IGNORE
   } state_t;

   state_t r_state;
   state_t w_state_nx;

   logic [1:0] r_sck_s;
   logic [1:0] r_cs_s;
   logic [1:0] r_mosi_s;
   logic       r_sck_d;
   logic       r_cs_d;

   logic [4:0]           r_cnt;
   logic [SW-1:0]        r_shift;
   logic                 r_is_wr;
   logic                 r_is_fast;
   logic [ADDR_BITS-1:0] r_addr;
   logic [ADDR_BITS-1:0] r_waddr;
   logic [7:0]           r_tx;
   logic [7:0]           r_pref;
   logic [7:0]           r_wdata;
   logic                 r_rd_req;
   logic                 r_pf_req;
   logic                 r_we;
   logic                 r_miso;
   logic                 r_oe;
   logic [7:0]           r_mem [DEPTH];

   logic                 w_sck_rise;
   logic                 w_sck_fall;
   logic                 w_cs_rise;
   logic                 w_cs_fall;
   logic                 w_mosi;
   logic [7:0]           w_byte;
   logic [ADDR_BITS-1:0] w_addr_in;
   logic [ADDR_BITS-1:0] w_addr_inc;
   logic                 w_cmd_ok;
   logic                 w_go_wr;
   logic                 w_go_fast;
   logic                 w_addr_done;
   logic                 w_rd_shift;
   logic                 w_wr_commit;
   logic                 w_cnt_inc;

   assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
   assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
   assign w_cs_rise  = r_cs_s[1] & ~r_cs_d;
   assign w_cs_fall  = ~r_cs_s[1] & r_cs_d;
   assign w_mosi     = r_mosi_s[1];
   assign w_byte     = {r_shift[6:0], w_mosi};
   assign w_addr_in  = {r_shift[ADDR_BITS-2:0], w_mosi};
   assign w_addr_inc = r_addr + A_ONE;

   assign spi_miso    = r_miso;
   assign spi_miso_oe = r_oe;

   always_comb begin
      w_state_nx  = r_state;
      w_cmd_ok    = 1'b0;
      w_go_wr     = 1'b0;
      w_go_fast   = 1'b0;
      w_addr_done = 1'b0;
      w_rd_shift  = 1'b0;
      w_wr_commit = 1'b0;
      w_cnt_inc   = (r_state == ST_READ) ? w_sck_fall : w_sck_rise;
      if (w_cs_rise) begin
         w_state_nx = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) w_state_nx = ST_CMD;
            end
            ST_CMD: begin
               if (w_sck_rise && r_cnt == 5'd7) begin
                  case (w_byte)
                     8'h03: begin
                        w_state_nx = ST_ADDR;
                        w_cmd_ok   = 1'b1;
                     end
                     8'h02: begin
                        w_state_nx = ST_ADDR;
                        w_cmd_ok   = 1'b1;
                        w_go_wr    = 1'b1;
                     end
`ifdef SPI_RESPONDER_FAST_READ_EN
                     8'h0B: begin
                        w_state_nx = ST_ADDR;
                        w_cmd_ok   = 1'b1;
                        w_go_fast  = 1'b1;
                     end
`endif
                     default: w_state_nx = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: begin
               if (w_sck_rise && r_cnt == 5'd23) begin
                  w_addr_done = 1'b1;
                  if (r_is_wr)        w_state_nx = ST_WRITE;
                  else if (r_is_fast) w_state_nx = ST_DUMMY;
                  else                w_state_nx = ST_READ;
               end
            end
            ST_DUMMY: begin
               if (w_sck_rise && r_cnt == 5'd7) w_state_nx = ST_READ;
            end
            ST_READ: begin
               w_rd_shift = w_sck_fall;
            end
            ST_WRITE: begin
               w_wr_commit = w_sck_rise && (r_cnt[2:0] == 3'd7);
            end
            ST_IGNORE: begin
               w_state_nx = ST_IGNORE;
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   // select sync resets low so a select held low across reset is not a new frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_s   <= '0;
         r_cs_s    <= '0;
         r_mosi_s  <= '0;
         r_sck_d   <= 1'b0;
         r_cs_d    <= 1'b0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_is_wr   <= 1'b0;
         r_is_fast <= 1'b0;
         r_addr    <= '0;
         r_waddr   <= '0;
         r_tx      <= '0;
         r_pref    <= '0;
         r_wdata   <= '0;
         r_rd_req  <= 1'b0;
         r_pf_req  <= 1'b0;
         r_we      <= 1'b0;
         r_miso    <= 1'b0;
         r_oe      <= 1'b0;
      end else begin
         r_sck_s  <= {r_sck_s[0], spi_clk};
         r_cs_s   <= {r_cs_s[0], spi_select};
         r_mosi_s <= {r_mosi_s[0], spi_mosi};
         r_sck_d  <= r_sck_s[1];
         r_cs_d   <= r_cs_s[1];
         r_state  <= w_state_nx;
         r_rd_req <= 1'b0;
         r_pf_req <= 1'b0;
         r_we     <= 1'b0;
         if (w_state_nx != r_state) r_cnt <= '0;
         else if (w_cnt_inc)        r_cnt <= r_cnt + 5'd1;
         if (w_sck_rise) r_shift <= {r_shift[SW-2:0], w_mosi};
         if (w_cmd_ok) begin
            r_is_wr   <= w_go_wr;
            r_is_fast <= w_go_fast;
         end
         if (w_addr_done) begin
            r_addr   <= w_addr_in;
            r_rd_req <= ~r_is_wr;
         end
         if (r_rd_req) begin
            r_tx     <= r_mem[r_addr];
            r_pf_req <= 1'b1;
         end
         if (r_pf_req) r_pref <= r_mem[w_addr_inc];
         if (w_rd_shift) begin
            r_miso <= r_tx[7];
            r_oe   <= 1'b1;
            if (r_cnt[2:0] == 3'd7) begin
               r_tx     <= r_pref;
               r_addr   <= w_addr_inc;
               r_pf_req <= 1'b1;
            end else begin
               r_tx <= {r_tx[6:0], 1'b0};
            end
         end
         if (w_wr_commit) begin
            r_we    <= 1'b1;
            r_wdata <= w_byte;
            r_waddr <= r_addr;
            r_addr  <= w_addr_inc;
         end
         if (w_cs_rise) begin
            r_miso <= 1'b0;
            r_oe   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_we) r_mem[r_waddr] <= r_wdata;
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: SPI initiator driver, byte-array memory model,
// and a MISO monitor that checks received bytes against a queue of expectations.
module tb_spi_sram_responder;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
   localparam int HALF  = 6;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic spi_clk    = 1'b0;
   logic spi_select = 1'b1;
   logic spi_mosi   = 1'b0;
   logic spi_miso;
   logic spi_miso_oe;

   int errors = 0;
   int checks = 0;

   logic [7:0] model [DEPTH];
   logic [7:0] exp_q [$];
   logic [7:0] wbuf [$];

   always #5 clk = ~clk;

   spi_sram_responder #(.ADDR_BITS(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_clk     (spi_clk),
      .spi_select  (spi_select),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe)
   );

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // monitor: the initiator samples MISO on rising spi_clk while oe is high
   int         mon_bits = 0;
   logic [7:0] mon_sr   = '0;
   logic [7:0] mon_exp;
   always @(posedge spi_clk or posedge spi_select or negedge rst_n) begin
      if (!rst_n || spi_select) begin
         mon_bits = 0;
      end else if (spi_miso_oe) begin
         mon_sr = {mon_sr[6:0], spi_miso};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %h expected none", mon_sr);
            end else begin
               mon_exp = exp_q.pop_front();
               check("miso_byte", {24'h0, mon_sr}, {24'h0, mon_exp});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bits(input logic [7:0] tx, input int n,
                       input logic exp_oe, input string name);
      logic got;
      got = exp_oe;
      for (int i = 7; i > 7 - n; i--) begin
         spi_mosi = tx[i];
         tick(HALF);
         spi_clk = 1'b1;
         if (spi_miso_oe !== exp_oe) got = spi_miso_oe;
         tick(HALF);
         spi_clk = 1'b0;
      end
      check(name, {31'h0, got}, {31'h0, exp_oe});
   endtask

   task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
      spi_select = 1'b0;
      tick(HALF);
      bits(cmd, 8, 1'b0, "oe_cmd");
      bits(a[23:16], 8, 1'b0, "oe_addr");
      bits(a[15:8], 8, 1'b0, "oe_addr");
      bits(a[7:0], 8, 1'b0, "oe_addr");
   endtask

   task automatic desel();
      tick(HALF);
      spi_select = 1'b1;
      tick(HALF);
      check("oe_after_desel", {31'h0, spi_miso_oe}, 32'h0);
      check("miso_after_desel", {31'h0, spi_miso}, 32'h0);
   endtask

   task automatic write_seq(input logic [23:0] a);
      hdr(8'h02, a);
      for (int k = 0; k < wbuf.size(); k++) begin
         bits(wbuf[k], 8, 1'b0, "oe_wdata");
         model[(int'(a[AW-1:0]) + k) % DEPTH] = wbuf[k];
      end
      desel();
   endtask

   task automatic read_seq(input logic [23:0] a, input int n);
      hdr(8'h03, a);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(model[(int'(a[AW-1:0]) + k) % DEPTH]);
         bits(8'($urandom), 8, 1'b1, "oe_rdata");
      end
      desel();
   endtask

   logic [23:0] ra;
   int          rn;

   initial begin
      tick(4);
      check("reset_miso", {31'h0, spi_miso}, 32'h0);
      check("reset_oe", {31'h0, spi_miso_oe}, 32'h0);
      rst_n = 1'b1;
      tick(HALF);
      check("post_reset_oe", {31'h0, spi_miso_oe}, 32'h0);

      wbuf = '{8'hA5, 8'h3C};
      write_seq(24'h000010);
      read_seq(24'h000010, 2);
      wbuf = '{8'h00, 8'h5A};
      write_seq(24'h000020);

      wbuf = '{8'h11, 8'h22};
      write_seq(24'h0003FF);
      read_seq(24'h000000, 1);
      read_seq(24'h0003FF, 2);

      hdr(8'h02, 24'h000020);
      bits(8'h77, 8, 1'b0, "oe_wdata");
      bits(8'hF0, 4, 1'b0, "oe_wpart");
      desel();
      model[32] = 8'h77;
      read_seq(24'h000020, 2);

      hdr(8'h9F, 24'(($urandom)));
      desel();
      read_seq(24'h000010, 2);
      read_seq(24'h000020, 2);
      read_seq(24'h0003FF, 2);

      hdr(8'h03, 24'h000010);
      exp_q.push_back(model[16]);
      bits(8'h00, 8, 1'b1, "oe_rdata");
      bits(8'h00, 3, 1'b1, "oe_rdata_part");
      tick(HALF);
      check("miso_pre_reset", {31'h0, spi_miso}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("miso_in_reset", {31'h0, spi_miso}, 32'h0);
      check("oe_in_reset", {31'h0, spi_miso_oe}, 32'h0);
      tick(3);
      spi_select = 1'b1;
      tick(HALF);
      rst_n = 1'b1;
      tick(HALF);
      read_seq(24'h000010, 1);

`ifdef SPI_RESPONDER_FAST_READ_EN
      hdr(8'h0B, 24'h000010);
      bits(8'h00, 8, 1'b0, "oe_dummy");
      exp_q.push_back(model[16]);
      bits(8'h00, 8, 1'b1, "oe_fast");
      desel();
`else
      hdr(8'h0B, 24'h000010);
      bits(8'h00, 8, 1'b0, "oe_fast_off");
      bits(8'h00, 8, 1'b0, "oe_fast_off");
      desel();
`endif

      for (int it = 0; it < 8; it++) begin
         ra = 24'($urandom);
         if (it % 3 == 0) ra[AW-1:0] = 10'(DEPTH - 1 - $urandom_range(0, 1));
         rn = $urandom_range(1, 4);
         wbuf.delete();
         for (int k = 0; k < rn; k++) wbuf.push_back(8'($urandom));
         write_seq(ra);
         ra[23:AW] = 14'($urandom);
         read_seq(ra, rn);
      end

      check("exp_queue_drained", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
